fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 29 ++
 rtl/ifid_reg.sv | 28 ++
 rtl/fetch_stage.sv | 102 ++++++++++
 tb/tb_fetch_stage.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcodes, NOP word, FSM encoding and IF/ID payload.
// Imported by ifid_reg and fetch_stage.
package fetch_stage_pkg;

  localparam logic [3:0]  OP_B     = 4'b1100;
  localparam logic [3:0]  OP_BR    = 4'b1101;
  localparam logic [3:0]  OP_HLT   = 4'b1111;
  localparam logic [15:0] NOP_WORD = 16'h0000;
  localparam logic [15:0] PC_RESET = 16'h0000;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc_plus2;
    logic        valid;
  } ifid_t;

  // Bubble contents; used for both reset and flush so ID always sees a NOP.
  localparam ifid_t IFID_EMPTY = '{instr: NOP_WORD, pc_plus2: 16'h0000, valid: 1'b0};

  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with write enable and flush; flush has priority over the enable.
module ifid_reg
  import fetch_stage_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_write_en,
  input  logic  i_flush,
  input  ifid_t i_data,
  output ifid_t o_data
);

  ifid_t r_data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= IFID_EMPTY;
    end else if (i_flush) begin
      r_data <= IFID_EMPTY;
    end else if (i_write_en) begin
      r_data <= i_data;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, RUN/HALT FSM and IF/ID register instance.
// Optional FETCH_STALL_CNT_EN adds a saturating Stall_cnt output.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        PC_write_en,
  input  logic        IFID_write_en,
  input  logic        Branch_taken,
  input  logic [15:0] Branch_target,
  input  logic [15:0] Instr_in,
  output logic [15:0] Imem_addr,
  output logic [15:0] IFID_instr,
  output logic [15:0] IFID_PC_plus2,
  output logic        IFID_valid,
`ifdef FETCH_STALL_CNT_EN
  output logic [15:0] Stall_cnt,
`endif
  output logic        Halt
);

  fetch_state_e r_state, w_state_next;
  logic [15:0]  r_pc, w_pc_next, w_pc_plus2;
  logic         w_ifid_we, w_flush;
  ifid_t        w_ifid_in, w_ifid_out;

  assign w_pc_plus2 = r_pc + 16'd2;  // natural 16-bit wrap 0xFFFE -> 0x0000

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_ifid_we    = 1'b0;
    w_flush      = 1'b0;
    if (Branch_taken) begin
      w_pc_next    = Branch_target;
      w_state_next = ST_RUN;
      w_flush      = 1'b1;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          w_ifid_we = IFID_write_en;
          if (PC_write_en) begin
            if (is_halt(Instr_in)) begin
              // HLT word goes to ID; PC parks on the HLT address.
              w_state_next = ST_HALT;
              w_ifid_we    = 1'b1;
            end else begin
              w_pc_next = w_pc_plus2;
            end
          end
        end
        ST_HALT: ;
        default: w_state_next = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_pc    <= PC_RESET;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  assign w_ifid_in = '{instr: Instr_in, pc_plus2: w_pc_plus2, valid: 1'b1};

  ifid_reg u_ifid_reg (
    .clk        (clk),
    .rst        (rst),
    .i_write_en (w_ifid_we),
    .i_flush    (w_flush),
    .i_data     (w_ifid_in),
    .o_data     (w_ifid_out)
  );

`ifdef FETCH_STALL_CNT_EN
  logic [15:0] r_stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cnt <= 16'h0000;
    end else if (r_state == ST_RUN && !PC_write_en && !Branch_taken &&
                 r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign Stall_cnt = r_stall_cnt;
`endif

  assign Imem_addr     = r_pc;
  assign IFID_instr    = w_ifid_out.instr;
  assign IFID_PC_plus2 = w_ifid_out.pc_plus2;
  assign IFID_valid    = w_ifid_out.valid;
  assign Halt          = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with hand-computed expectations.
// Checks Stall_cnt too when built with FETCH_STALL_CNT_EN.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        PC_write_en, IFID_write_en, Branch_taken;
  logic [15:0] Branch_target, Instr_in;
  logic [15:0] Imem_addr, IFID_instr, IFID_PC_plus2;
  logic        IFID_valid, Halt;
`ifdef FETCH_STALL_CNT_EN
  logic [15:0] Stall_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .PC_write_en   (PC_write_en),
    .IFID_write_en (IFID_write_en),
    .Branch_taken  (Branch_taken),
    .Branch_target (Branch_target),
    .Instr_in      (Instr_in),
    .Imem_addr     (Imem_addr),
    .IFID_instr    (IFID_instr),
    .IFID_PC_plus2 (IFID_PC_plus2),
    .IFID_valid    (IFID_valid),
`ifdef FETCH_STALL_CNT_EN
    .Stall_cnt     (Stall_cnt),
`endif
    .Halt          (Halt)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic pc_we, input logic ifid_we, input logic br,
                       input logic [15:0] tgt, input logic [15:0] instr);
    PC_write_en   = pc_we;
    IFID_write_en = ifid_we;
    Branch_taken  = br;
    Branch_target = tgt;
    Instr_in      = instr;
  endtask

  task automatic check_ifid(input string tag, input logic [15:0] instr,
                            input logic [15:0] pc2, input logic valid);
    check({tag, "_instr"}, IFID_instr, instr);
    check({tag, "_pc2"}, IFID_PC_plus2, pc2);
    check({tag, "_valid"}, {15'd0, IFID_valid}, {15'd0, valid});
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000);
    #2;
    check("rst_addr", Imem_addr, 16'h0000);
    check_ifid("rst", 16'h0000, 16'h0000, 1'b0);
    check("rst_halt", {15'd0, Halt}, 16'd0);
    rst = 1'b0;

    // Sequential fetch: PC 0,2,4,6 with IF/ID one cycle behind.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1000 + 16'(i));
      step();
      check($sformatf("seq%0d_addr", i), Imem_addr, 16'(2 * (i + 1)));
      check_ifid($sformatf("seq%0d", i), 16'h1000 + 16'(i), 16'(2 * (i + 1)), 1'b1);
    end

    // HLT at PC 0x0008 parks the PC and freezes IF/ID whatever the enables do.
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'hF000);
    step();
    check("hlt_halt", {15'd0, Halt}, 16'd1);
    check("hlt_addr", Imem_addr, 16'h0008);
    check_ifid("hlt", 16'hF000, 16'h000A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(i[0], ~i[0], 1'b0, 16'h0000, 16'h2000 + 16'(i));
      step();
      check($sformatf("hold%0d_addr", i), Imem_addr, 16'h0008);
      check($sformatf("hold%0d_instr", i), IFID_instr, 16'hF000);
      check($sformatf("hold%0d_halt", i), {15'd0, Halt}, 16'd1);
    end
    drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h1111);
    step();
    check("unhalt_halt", {15'd0, Halt}, 16'd0);
    check("unhalt_addr", Imem_addr, 16'h0040);
    check_ifid("unhalt", 16'h0000, 16'h0000, 1'b0);

    // Reach PC 0x0010 with a valid IF/ID entry, then stall both stages for 3 cycles.
    drive(1'b1, 1'b1, 1'b1, 16'h000E, 16'h1111);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1234);
    step();
    check("pre_stall_addr", Imem_addr, 16'h0010);
    check_ifid("pre_stall", 16'h1234, 16'h0010, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h3000 + 16'(i));
      step();
      check($sformatf("stall%0d_addr", i), Imem_addr, 16'h0010);
      check_ifid($sformatf("stall%0d", i), 16'h1234, 16'h0010, 1'b1);
    end
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt", Stall_cnt, 16'd3);
`endif

    // IF/ID held while PC still advances.
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h4444);
    step();
    check("ifid_hold_addr", Imem_addr, 16'h0012);
    check_ifid("ifid_hold", 16'h1234, 16'h0010, 1'b1);

    // Flush beats stall: redirect from 0x0020 with PC_write_en=0.
    drive(1'b1, 1'b1, 1'b1, 16'h001E, 16'h1111);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h5555);
    step();
    check("pre_flush_addr", Imem_addr, 16'h0020);
    check_ifid("pre_flush", 16'h5555, 16'h0020, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 16'h0100, 16'h6666);
    step();
    check("flush_addr", Imem_addr, 16'h0100);
    check_ifid("flush", 16'h0000, 16'h0000, 1'b0);
`ifdef FETCH_STALL_CNT_EN
    check("stall_cnt_flush", Stall_cnt, 16'd3);
`endif

    // PC wrap at 0xFFFE.
    drive(1'b1, 1'b1, 1'b1, 16'hFFFE, 16'h1111);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h7777);
    step();
    check("wrap_addr", Imem_addr, 16'h0000);
    check_ifid("wrap", 16'h7777, 16'h0000, 1'b1);

    // Asynchronous reset while halted takes effect before the next edge.
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'hF123);
    step();
    check("hlt2_halt", {15'd0, Halt}, 16'd1);
    drive(1'b1, 1'b1, 1'b1, 16'h0200, 16'h1111);
    #2;
    rst = 1'b1;
    #1;
    check("arst_halt", {15'd0, Halt}, 16'd0);
    check("arst_addr", Imem_addr, 16'h0000);
    check_ifid("arst", 16'h0000, 16'h0000, 1'b0);
    step();
    drive(1'b1, 1'b1, 1'b0, 16'h0000, 16'h1ABC);
    #2;
    rst = 1'b0;
    check("post_rst_addr", Imem_addr, 16'h0000);
    step();
    check("post_rst_next", Imem_addr, 16'h0002);
    check_ifid("post_rst", 16'h1ABC, 16'h0002, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
